fib_pulse_checker: RTL and testbench

- Downstream consumer of the Fibonacci breathing PWM generator's pwm_out.
- Synchronises the PWM line, measures every HIGH pulse width in clock cycles, and compares each width against an internally generated Fibonacci sequence 1,1,2,3,5,…,MAX_FIB, wrapping back to 1,1.
- Results are queued in a small FIFO and drained over a valid/ready interface. Sticky error and overflow flags are kept for in-system self-check and bench scoreboarding.

---
 rtl/fib_pwm_pkg.sv | 32 +++
 rtl/fib_result_fifo.sv | 44 ++++
 rtl/fib_pulse_checker.sv | 119 +++++++++++
 tb/tb_fib_pulse_checker.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pwm_pkg.sv
// rtl/fib_pwm_pkg.sv - shared types, defaults and Fibonacci step for the PWM pulse checker
package fib_pwm_pkg;
  localparam int DEFAULT_WIDTH_W = 16;
  localparam int DEFAULT_MAX_FIB = 34;

  typedef struct packed {
    logic [DEFAULT_WIDTH_W-1:0] width;
    logic                       match;
  } fib_result_t;

  localparam int RESULT_W = $bits(fib_result_t);

  typedef struct packed {
    logic [DEFAULT_WIDTH_W-1:0] a;
    logic [DEFAULT_WIDTH_W-1:0] b;
  } fib_pair_t;

  // Once b has passed the last term the sequence restarts at 1,1.
  function automatic fib_pair_t next_fib(input logic [DEFAULT_WIDTH_W-1:0] a,
                                         input logic [DEFAULT_WIDTH_W-1:0] b,
                                         input logic [DEFAULT_WIDTH_W-1:0] max_fib);
    fib_pair_t nxt;
    if (b > max_fib) begin
      nxt.a = DEFAULT_WIDTH_W'(1);
      nxt.b = DEFAULT_WIDTH_W'(1);
    end else begin
      nxt.a = b;
      nxt.b = a + b;
    end
    return nxt;
  endfunction
endpackage

// File: rtl/fib_result_fifo.sv
// rtl/fib_result_fifo.sv - synchronous result FIFO, head entry visible combinationally
module fib_result_fifo
  import fib_pwm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [RESULT_W-1:0] push_data,
  input  logic                pop,
  output logic [RESULT_W-1:0] head,
  output logic                full,
  output logic                empty
);
  localparam int AW = $clog2(DEPTH);

  fib_result_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= fib_result_t'(push_data);
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/fib_pulse_checker.sv
// rtl/fib_pulse_checker.sv - measures PWM high pulses and checks them against a Fibonacci sequence
module fib_pulse_checker
  import fib_pwm_pkg::*;
#(
  parameter int WIDTH_W     = DEFAULT_WIDTH_W,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_FIB     = DEFAULT_MAX_FIB,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clear,
  input  logic               pwm_in,
  output logic [WIDTH_W-1:0] width_out,
  output logic               match_out,
  output logic               width_valid,
  input  logic               width_ready,
  output logic               err_sticky,
  output logic               overflow,
  output logic [15:0]        pulse_count
);
  localparam logic [WIDTH_W-1:0] FIB_ONE = WIDTH_W'(1);

  logic               s;
  logic               s_d;
  logic               fall;
  logic               armed;
  logic               sat;
  logic               check;
  logic               match;
  logic [WIDTH_W-1:0] cnt;
  logic [WIDTH_W-1:0] fib_a;
  logic [WIDTH_W-1:0] fib_b;
  fib_pair_t          fib_next;
  fib_result_t        push_data;
  fib_result_t        head;
  logic               fifo_full;
  logic               fifo_empty;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = pwm_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= (sync_q << 1) | SYNC_STAGES'(pwm_in);
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign fall     = s_d & ~s;
  assign check    = en & armed & fall;
  assign match    = (cnt == fib_a) & ~sat;
  assign fib_next = next_fib(fib_a, fib_b, WIDTH_W'(MAX_FIB));

  always_comb begin
    push_data       = '0;
    push_data.width = cnt;
    push_data.match = match;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_d         <= 1'b0;
      armed       <= 1'b0;
      cnt         <= '0;
      sat         <= 1'b0;
      fib_a       <= FIB_ONE;
      fib_b       <= FIB_ONE;
      err_sticky  <= 1'b0;
      overflow    <= 1'b0;
      pulse_count <= '0;
    end else begin
      s_d <= s;
      // Disabled: drop any partial pulse and restart the expected sequence.
      if (!en) begin
        armed <= 1'b0;
        cnt   <= '0;
        sat   <= 1'b0;
        fib_a <= FIB_ONE;
        fib_b <= FIB_ONE;
      end else begin
        if (!s) armed <= 1'b1;
        if (check) begin
          cnt   <= '0;
          sat   <= 1'b0;
          fib_a <= fib_next.a;
          fib_b <= fib_next.b;
        end else if (armed && s) begin
          if (&cnt) sat <= 1'b1;
          else      cnt <= cnt + 1'b1;
        end
      end
      err_sticky  <= (err_sticky & ~clear) | (check & ~match);
      overflow    <= (overflow & ~clear) | (check & fifo_full & ~width_ready);
      pulse_count <= clear ? 16'(check) : pulse_count + 16'(check);
    end
  end

  fib_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (check),
    .push_data(push_data),
    .pop      (width_ready),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign width_valid = ~fifo_empty;
  assign width_out   = head.width;
  assign match_out   = head.match;
endmodule

// File: tb/tb_fib_pulse_checker.sv
// tb/tb_fib_pulse_checker.sv - self-checking bench for fib_pulse_checker
module tb_fib_pulse_checker;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_FIB    = 34;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic        pwm_in = 1'b0;
  logic        width_ready = 1'b0;
  logic [15:0] width_out;
  logic        match_out;
  logic        width_valid;
  logic        err_sticky;
  logic        overflow;
  logic [15:0] pulse_count;

  fib_pulse_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clear      (clear),
    .pwm_in     (pwm_in),
    .width_out  (width_out),
    .match_out  (match_out),
    .width_valid(width_valid),
    .width_ready(width_ready),
    .err_sticky (err_sticky),
    .overflow   (overflow),
    .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int width;
    bit match;
  } exp_t;

  exp_t exp_q[$];
  int   terms[$];
  int   m_idx;
  int   m_pc;
  bit   m_err;
  bit   m_ovf;
  bit   same_pop = 1'b0;

  function automatic void build_terms();
    terms = {1, 1};
    while (terms[$] + terms[$-1] <= MAX_FIB) terms.push_back(terms[$] + terms[$-1]);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_idx = 0;
    m_pc  = 0;
    m_err = 1'b0;
    m_ovf = 1'b0;
  endfunction

  function automatic void model_clear();
    m_pc  = 0;
    m_err = 1'b0;
    m_ovf = 1'b0;
  endfunction

  function automatic void model_fall(input int w);
    exp_t e;
    e.width = w;
    e.match = (w == terms[m_idx]);
    m_idx   = (m_idx + 1) % terms.size();
    m_pc    = (m_pc + 1) % 65536;
    if (!e.match) m_err = 1'b1;
    if (!width_ready && !same_pop && exp_q.size() >= FIFO_DEPTH) m_ovf = 1'b1;
    else exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst_n && width_valid && width_ready) begin
      if (exp_q.size() == 0) begin
        chk("result_expected", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_width", width_out, e.width);
        chk("res_match", match_out, e.match);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_pulse(input int w, input int gap);
    pwm_in = 1'b1;
    repeat (w) @(posedge clk);
    #1;
    pwm_in = 1'b0;
    model_fall(w);
    wait_cyc(gap);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_state(input string tag);
    wait_cyc(2);
    chk({tag, "_err"}, err_sticky, m_err);
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_pc"}, pulse_count, m_pc);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    wait_cyc(1);
    clear = 1'b0;
    model_clear();
  endtask

  initial begin
    build_terms();
    en          = 1'b1;
    width_ready = 1'b1;
    rst_n       = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    model_reset();
    chk("rst_width", width_out, 0);
    chk("rst_match", match_out, 0);
    chk("rst_valid", width_valid, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_pc", pulse_count, 0);

    // Full sequence then the wrap back to 1,1.
    for (int i = 0; i < terms.size(); i++) drive_pulse(terms[i], 3);
    check_state("basic9");
    chk("basic9_pc_abs", pulse_count, 9);
    drive_pulse(1, 3);
    drive_pulse(1, 3);
    check_state("wrap");
    chk("wrap_err_abs", err_sticky, 0);
    chk("wrap_drained", exp_q.size(), 0);

    // Mismatch: 1,1,4 then the sequence continues with 3,5.
    do_reset();
    drive_pulse(1, 3);
    drive_pulse(1, 3);
    pwm_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    pwm_in = 1'b0;
    model_fall(4);
    wait_cyc(2);
    chk("err_before_push", err_sticky, 0);
    wait_cyc(1);
    chk("err_after_push", err_sticky, 1);
    drive_pulse(3, 3);
    drive_pulse(5, 3);
    check_state("mismatch");

    pulse_clear();
    chk("clear_err", err_sticky, 0);
    chk("clear_pc", pulse_count, 0);

    // Result latency through the two-stage synchroniser.
    do_reset();
    pwm_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pwm_in = 1'b0;
    model_fall(3);
    wait_cyc(2);
    chk("lat_edge2_valid", width_valid, 0);
    wait_cyc(1);
    chk("lat_edge3_valid", width_valid, 1);
    chk("lat_edge3_width", width_out, 3);
    check_state("latency");

    // A pulse already high when en rises is not measured.
    en = 1'b0;
    do_reset();
    pwm_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    pwm_in = 1'b0;
    wait_cyc(4);
    chk("preen_not_counted", pulse_count, 0);
    drive_pulse(1, 3);
    check_state("preen");
    chk("preen_drained", exp_q.size(), 0);

    // Randomised mix of correct and wrong widths with varying gaps.
    for (int i = 0; i < 40; i++) begin
      int w;
      w = ($urandom % 4 != 0) ? terms[m_idx] : int'($urandom_range(1, 40));
      drive_pulse(w, int'($urandom_range(1, 5)));
    end
    wait_cyc(4);
    check_state("random");

    // Backpressure: four entries kept, two dropped.
    do_reset();
    width_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive_pulse(terms[i], 3);
    check_state("bp");
    chk("bp_ovf_abs", overflow, 1);
    chk("bp_pc_abs", pulse_count, 6);
    chk("bp_head", width_out, 1);
    width_ready = 1'b1;
    wait_cyc(6);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_valid_low", width_valid, 0);

    // Full FIFO with push and pop landing on the same edge.
    width_ready = 1'b0;
    pulse_clear();
    for (int i = 6; i < 10; i++) drive_pulse(terms[i % terms.size()], 3);
    chk("refill_ovf", overflow, 0);
    pwm_in = 1'b1;
    @(posedge clk);
    #1;
    pwm_in   = 1'b0;
    same_pop = 1'b1;
    model_fall(1);
    same_pop = 1'b0;
    wait_cyc(2);
    width_ready = 1'b1;
    wait_cyc(1);
    width_ready = 1'b0;
    check_state("pushpop");
    chk("pushpop_ovf_abs", overflow, 0);
    width_ready = 1'b1;
    wait_cyc(6);
    chk("pushpop_drained", exp_q.size(), 0);

    // Reset in the middle of a 13-cycle pulse with results pending.
    width_ready = 1'b0;
    drive_pulse(7, 3);
    pwm_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    model_reset();
    chk("midrst_valid", width_valid, 0);
    chk("midrst_width", width_out, 0);
    chk("midrst_match", match_out, 0);
    chk("midrst_err", err_sticky, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_pc", pulse_count, 0);
    repeat (6) @(posedge clk);
    #1;
    pwm_in = 1'b0;
    model_fall(6);
    wait_cyc(3);
    drive_pulse(1, 3);
    width_ready = 1'b1;
    check_state("midrst_after");
    wait_cyc(4);

    chk("final_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
